// File: rtl/router_port_drain.sv
// Drains one router output port (header, payload, parity) and re-emits
// the header/payload as a valid/ready byte stream with per-packet status.
module router_port_drain #(
  parameter int PORT_ID      = 0,
  parameter bit PASS_HDR     = 1'b1,
  parameter int ABORT_CYCLES = 32
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out,
  input  logic [7:0] data_in,
  output logic       read_enb,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       sts_valid,
  output logic [5:0] sts_len,
  output logic       sts_parity_err,
  output logic       sts_addr_err,
  output logic       sts_abort
);

  localparam logic [1:0] PID = 2'(PORT_ID);
  localparam logic [7:0] AB_LAST = 8'(ABORT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, PLD, PAR, DRAIN
  } state_t;

  state_t state, state_nxt;

  logic       rd_pend;
  logic [6:0] rd_rem;
  logic [5:0] len;
  logic [5:0] pld_cnt;
  logic [7:0] par_acc;
  logic       par_err;
  logic       addr_err;
  logic [7:0] ab_cnt;

  logic [1:0] cnt;
  logic [7:0] b0_d, b1_d;
  logic       b0_l, b1_l;

  logic       active;
  logic       waiting;
  logic       issue_ok;
  logic       slot_ok;
  logic       timeout;
  logic       cap;
  logic       pld_last;
  logic       push;
  logic       push_l;
  logic       pop;
  logic       done;
  logic [5:0] hdr_len;

  assign hdr_len  = data_in[7:2];
  assign cap      = rd_pend;
  assign active   = state inside {HDR, PLD, PAR};
  assign pld_last = (pld_cnt == len - 6'd1);

  // HDR always has bytes still owed; elsewhere only unissued reads count
  assign waiting = (state == HDR) || (rd_rem != 7'd0);
  assign timeout = active && waiting && !vld_out
                && (ab_cnt == AB_LAST);

  assign issue_ok = (state == IDLE)
                 || (active && rd_rem != 7'd0);
  assign slot_ok  = ({1'b0, cnt} + {2'b0, rd_pend}) < 3'd2;
  assign read_enb = resetn && vld_out && issue_ok && slot_ok;

  assign push = cap && !timeout
             && ((state == HDR && PASS_HDR) || state == PLD);
  assign push_l = (state == HDR) ? (hdr_len == 6'd0) : pld_last;
  assign pop  = m_valid && m_ready;
  assign done = (state == DRAIN) && (cnt == 2'd0);

  assign m_valid = (cnt != 2'd0);
  assign m_data  = b0_d;
  assign m_last  = m_valid && b0_l;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (read_enb) state_nxt = HDR;
      HDR:   if (cap) state_nxt = (hdr_len == 6'd0) ? PAR : PLD;
      PLD:   if (cap && pld_last) state_nxt = PAR;
      PAR:   if (cap) state_nxt = DRAIN;
      DRAIN: if (cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_pend  <= 1'b0;
      rd_rem   <= '0;
      len      <= '0;
      pld_cnt  <= '0;
      par_acc  <= '0;
      par_err  <= 1'b0;
      addr_err <= 1'b0;
      ab_cnt   <= '0;
    end else begin
      rd_pend <= read_enb && !timeout;
      if (state == IDLE && read_enb) begin
        rd_rem   <= '0;
        len      <= '0;
        pld_cnt  <= '0;
        par_acc  <= '0;
        par_err  <= 1'b0;
        addr_err <= 1'b0;
      end else if (state == HDR && cap) begin
        rd_rem   <= {1'b0, hdr_len} + 7'd1;
        len      <= hdr_len;
        addr_err <= (data_in[1:0] != PID);
        par_acc  <= data_in;
      end else begin
        if (read_enb) rd_rem <= rd_rem - 7'd1;
        if (state == PLD && cap) begin
          par_acc <= par_acc ^ data_in;
          pld_cnt <= pld_cnt + 6'd1;
        end
        if (state == PAR && cap)
          par_err <= (data_in != par_acc);
      end
      if (active && waiting && !vld_out && !timeout)
        ab_cnt <= ab_cnt + 8'd1;
      else
        ab_cnt <= '0;
    end
  end

  // two-entry skid buffer, b0 is the head
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      b0_d <= '0;
      b1_d <= '0;
      b0_l <= 1'b0;
      b1_l <= 1'b0;
    end else if (timeout) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            b0_d <= data_in;
            b0_l <= push_l;
          end else begin
            b1_d <= data_in;
            b1_l <= push_l;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          b0_d <= b1_d;
          b0_l <= b1_l;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            b0_d <= data_in;
            b0_l <= push_l;
          end else begin
            b0_d <= b1_d;
            b0_l <= b1_l;
            b1_d <= data_in;
            b1_l <= push_l;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sts_valid      <= 1'b0;
      sts_len        <= '0;
      sts_parity_err <= 1'b0;
      sts_addr_err   <= 1'b0;
      sts_abort      <= 1'b0;
    end else begin
      sts_valid <= 1'b0;
      if (done || timeout) begin
        sts_valid      <= 1'b1;
        sts_len        <= len;
        sts_parity_err <= par_err;
        sts_addr_err   <= addr_err;
        sts_abort      <= timeout;
      end
    end
  end

endmodule
